// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin search used by the memory-port arbiter.
package mem_arb_pkg;

  // Upper bound on requester count; rr_select works on vectors of this width.
  localparam int unsigned MaxPorts = 64;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // First set bit of req at or above ptr, wrapping at num_ports; returns ptr when req is empty.
  function automatic int unsigned rr_select(input logic [MaxPorts-1:0] req,
                                            input int unsigned         ptr,
                                            input int unsigned         num_ports);
    int unsigned sel;
    int unsigned idx;
    logic        found;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      idx = ptr + i;
      if (idx >= num_ports) idx = idx - num_ports;
      if (!found && (i < num_ports) && req[idx[5:0]]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_arb_idx_fifo.sv
// Small FIFO remembering which port owns each outstanding memory request, in issue order.
module mem_arb_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; only pointers and count define validity, so entries need no clearing.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign full  = (count_q == CntWidth'(Depth));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt memory port among several requesters,
// with a lock on stalled requests and in-order response routing.
module mem_port_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 128,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             slv_req_i,
  output logic [NumPorts-1:0]             slv_gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]   slv_addr_i,
  input  logic [NumPorts-1:0]             slv_we_i,
  input  logic [NumPorts*DataWidth-1:0]   slv_wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0] slv_strb_i,
  output logic [NumPorts-1:0]             slv_rvalid_o,
  output logic [DataWidth-1:0]            slv_rdata_o,
  output logic                            mst_req_o,
  input  logic                            mst_gnt_i,
  output logic [AddrWidth-1:0]            mst_addr_o,
  output logic                            mst_we_o,
  output logic [DataWidth-1:0]            mst_wdata_o,
  output logic [DataWidth/8-1:0]          mst_strb_o,
  input  logic                            mst_rvalid_i,
  input  logic [DataWidth-1:0]            mst_rdata_i,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int unsigned IdxWidth  = $clog2(NumPorts);
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] strb;
  } mem_req_t;

  mem_req_t            port_req [NumPorts];
  mem_req_t            sel_req;
  lock_state_t         state_q, state_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] sel, fifo_head;
  logic                lock_active, handshake, stall, pop;
  logic                fifo_full, fifo_empty, err_q;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      port_req[p].addr  = slv_addr_i[p*AddrWidth +: AddrWidth];
      port_req[p].we    = slv_we_i[p];
      port_req[p].wdata = slv_wdata_i[p*DataWidth +: DataWidth];
      port_req[p].strb  = slv_strb_i[p*StrbWidth +: StrbWidth];
    end
  end

  // A locked port keeps the slot until its stalled request is accepted.
  assign lock_active = (state_q == LOCKED);
  assign sel = lock_active ? lock_idx_q
                           : IdxWidth'(rr_select(MaxPorts'(slv_req_i), 32'(rr_ptr_q), NumPorts));

  assign mst_req_o = (lock_active | (|slv_req_i)) & ~fifo_full & ~rst_i;
  assign handshake = mst_req_o & mst_gnt_i;
  assign stall     = mst_req_o & ~mst_gnt_i & ~lock_active;
  assign pop       = mst_rvalid_i & ~fifo_empty & ~rst_i;

  assign sel_req     = port_req[sel];
  assign mst_addr_o  = rst_i ? '0 : sel_req.addr;
  assign mst_we_o    = ~rst_i & sel_req.we;
  assign mst_wdata_o = rst_i ? '0 : sel_req.wdata;
  assign mst_strb_o  = rst_i ? '0 : sel_req.strb;
  assign slv_rdata_o = rst_i ? '0 : mst_rdata_i;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    slv_gnt_o    = '0;
    slv_rvalid_o = '0;
    if (handshake) slv_gnt_o[sel]          = 1'b1;
    if (pop)       slv_rvalid_o[fifo_head] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (handshake)
      rr_ptr_d = (sel == IdxWidth'(NumPorts - 1)) ? '0 : sel + 1'b1;
    case (state_q)
      UNLOCKED: if (stall) begin
        state_d    = LOCKED;
        lock_idx_d = sel;
      end
      LOCKED:   if (handshake) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      if (mst_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  mem_arb_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxWidth)
  ) u_idx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (handshake),
    .push_data (sel),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign busy_o = ~fifo_empty | lock_active;
  assign err_o  = err_q;

endmodule
